// File: rtl/alu_seq_div.sv
// Iterative restoring sign-magnitude divider: one quotient bit per clock, MSB first.
// It is the inverse of the ALU's sign-magnitude multiplier.
module alu_seq_div #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [31:0]      div_result,
    output logic             dz,
    output logic             ovf
);
    localparam int MAG   = WIDTH - 1;
    localparam int ITER  = WIDTH - 1 + FRAC;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             zpend_q, zpend_d;
    logic             sign_q, sign_d;
    logic [ITER-1:0]  dvd_q, dvd_d;
    logic [MAG-1:0]   dvs_q, dvs_d;
    logic [MAG-1:0]   rem_q, rem_d;
    logic [ITER-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [MAG:0]     rem_sh_s;
    logic [MAG:0]     rem_sub_s;
    logic             sub_ok_s;
    logic [ITER-1:0]  q_fin_s;

    // Restoring step datapath and FSM next-state / output decode.
    always_comb begin
        state_d  = state_q;
        zpend_d  = 1'b0;
        sign_d   = sign_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        // rem_q is always below the divisor, so the shifted value fits in MAG+1 bits.
        rem_sh_s  = {rem_q, dvd_q[ITER-1]};
        sub_ok_s  = (rem_sh_s >= {1'b0, dvs_q});
        rem_sub_s = rem_sh_s - {1'b0, dvs_q};
        q_fin_s   = {quo_q[ITER-2:0], sub_ok_s};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (zpend_q) begin
                    // Zero divisor: latched one edge earlier, reported now with no iterations.
                    state_d = ST_DONE;
                    res_d   = {{(32-MAG){sign_q}}, {MAG{1'b1}}};
                    dz_d    = 1'b1;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (start) begin
                    sign_d = A[MAG] ^ B[MAG];
                    dvd_d  = {A[MAG-1:0], {FRAC{1'b0}}};
                    dvs_d  = B[MAG-1:0];
                    rem_d  = {MAG{1'b0}};
                    quo_d  = {ITER{1'b0}};
                    cnt_d  = {CNT_W{1'b0}};
                    if (B[MAG-1:0] == {MAG{1'b0}}) begin
                        zpend_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                busy_d = 1'b1;
                rem_d  = sub_ok_s ? rem_sub_s[MAG-1:0] : rem_sh_s[MAG-1:0];
                quo_d  = q_fin_s;
                dvd_d  = {dvd_q[ITER-2:0], 1'b0};
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    if (q_fin_s[ITER-1:MAG] != {(ITER-MAG){1'b0}}) begin
                        res_d = {{(32-MAG){sign_q}}, {MAG{1'b1}}};
                        ovf_d = 1'b1;
                    end else begin
                        res_d = {{(32-MAG){sign_q}}, q_fin_s[MAG-1:0]};
                        ovf_d = 1'b0;
                    end
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            zpend_q <= 1'b0;
            sign_q  <= 1'b0;
            dvd_q   <= {ITER{1'b0}};
            dvs_q   <= {MAG{1'b0}};
            rem_q   <= {MAG{1'b0}};
            quo_q   <= {ITER{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            res_q   <= 32'h0000_0000;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zpend_q <= zpend_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign div_result = res_q;
    assign dz         = dz_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_alu_seq_div.sv
// Self-checking bench for alu_seq_div: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_alu_seq_div;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [31:0] div_result;
    logic        dz;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    alu_seq_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .div_result (div_result),
        .dz         (dz),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Q3.12 magnitude divide with plain integer arithmetic.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] r, output logic edz, output logic eovf);
        logic [63:0] q;
        logic [14:0] m;
        logic        s;
        s = a[15] ^ b[15];
        if (b[14:0] == 15'd0) begin
            m = 15'h7FFF; edz = 1'b1; eovf = 1'b0;
        end else begin
            q = ({49'd0, a[14:0]} * 64'd4096) / {49'd0, b[14:0]};
            edz = 1'b0;
            if (q > 64'd32767) begin
                m = 15'h7FFF; eovf = 1'b1;
            end else begin
                m = q[14:0]; eovf = 1'b0;
            end
        end
        r = {{17{s}}, m};
    endfunction

    // Launch one operation from the current (between-edge) time; return after done is seen.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit hold,
                         output int lat, output int busy_cnt, output bit overlap);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        lat = 0; busy_cnt = 0; overlap = 1'b0;
        if (!hold) start = 1'b0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (hold) begin
                A = 16'($urandom); B = 16'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = 16'h0000; B = 16'h0000;
        #13;
        checks++;
        if ({busy, done, dz, ovf, div_result} !== 36'h0)
            begin errors++; $display("FAIL reset_outputs got=%h want=0", {busy, done, dz, ovf, div_result}); end
        @(negedge clk); rst_n = 1'b1;
        idle(2);
        checks++;
        if ({busy, done} !== 2'b00)
            begin errors++; $display("FAIL reset_idle got=%b want=00", {busy, done}); end
    endtask

    task automatic test_unit();
        int lat, bc; bit ov;
        idle(2);
        do_op(16'h1000, 16'h1000, 1'b0, lat, bc, ov);
        checks++; if (lat !== 27) begin errors++; $display("FAIL unit_latency got=%0d want=27", lat); end
        checks++; if (bc !== 27) begin errors++; $display("FAIL unit_busy got=%0d want=27", bc); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL unit_overlap got=1 want=0"); end
        checks++; if ({div_result, dz, ovf} !== {32'h0000_1000, 2'b00})
            begin errors++; $display("FAIL unit_result got=%h dz=%b ovf=%b want=00001000 0 0", div_result, dz, ovf); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b want=0", done); end
    endtask

    task automatic test_signed();
        int lat, bc; bit ov;
        idle(1);
        do_op(16'h9000, 16'h2000, 1'b0, lat, bc, ov);
        checks++; if (div_result !== 32'hFFFF_8800)
            begin errors++; $display("FAIL signed_neg got=%h want=ffff8800", div_result); end
        idle(1);
        do_op(16'h8800, 16'h8800, 1'b0, lat, bc, ov);
        checks++; if (div_result !== 32'h0000_1000)
            begin errors++; $display("FAIL signed_negneg got=%h want=00001000", div_result); end
    endtask

    task automatic test_dz();
        int lat, bc; bit ov;
        idle(1);
        do_op(16'h1234, 16'h0000, 1'b0, lat, bc, ov);
        checks++; if (lat !== 1 || bc !== 0)
            begin errors++; $display("FAIL dz_pos_timing got lat=%0d busy=%0d want 1 0", lat, bc); end
        checks++; if ({div_result, dz, ovf} !== {32'h0000_7FFF, 2'b10})
            begin errors++; $display("FAIL dz_pos_result got=%h dz=%b ovf=%b want=00007fff 1 0", div_result, dz, ovf); end
        idle(1);
        do_op(16'h1234, 16'h8000, 1'b0, lat, bc, ov);
        checks++; if (lat !== 1 || bc !== 0)
            begin errors++; $display("FAIL dz_neg_timing got lat=%0d busy=%0d want 1 0", lat, bc); end
        checks++; if ({div_result, dz, ovf} !== {32'hFFFF_FFFF, 2'b10})
            begin errors++; $display("FAIL dz_neg_result got=%h dz=%b ovf=%b want=ffffffff 1 0", div_result, dz, ovf); end
    endtask

    task automatic test_ovf_trunc();
        int lat, bc; bit ov;
        idle(1);
        do_op(16'h7FFF, 16'h0001, 1'b0, lat, bc, ov);
        checks++; if ({div_result, dz, ovf} !== {32'h0000_7FFF, 2'b01})
            begin errors++; $display("FAIL ovf_result got=%h dz=%b ovf=%b want=00007fff 0 1", div_result, dz, ovf); end
        idle(3);
        checks++; if ({div_result, ovf} !== {32'h0000_7FFF, 1'b1})
            begin errors++; $display("FAIL ovf_hold got=%h ovf=%b want=00007fff 1", div_result, ovf); end
        do_op(16'h1000, 16'h3000, 1'b0, lat, bc, ov);
        checks++; if ({div_result, dz, ovf} !== {32'h0000_0555, 2'b00})
            begin errors++; $display("FAIL trunc_result got=%h dz=%b ovf=%b want=00000555 0 0", div_result, dz, ovf); end
    endtask

    task automatic test_random();
        int lat, bc; bit ov;
        logic [15:0] a, b;
        logic [31:0] er; logic edz, eovf;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0: b = 16'($urandom);
                1: b = {1'($urandom), 15'($urandom_range(1, 255))};
                2: b = {1'($urandom), 15'($urandom_range(4096, 32767))};
                default: b = (i % 8 == 3) ? {1'($urandom), 15'd0} : 16'($urandom);
            endcase
            model(a, b, er, edz, eovf);
            if (i % 3 == 0) idle(1);
            do_op(a, b, 1'b0, lat, bc, ov);
            checks++;
            if ({div_result, dz, ovf} !== {er, edz, eovf} || lat !== (edz ? 1 : 27) || ov)
                begin errors++; $display("FAIL random a=%h b=%h got=%h dz=%b ovf=%b lat=%0d want=%h dz=%b ovf=%b", a, b, div_result, dz, ovf, lat, er, edz, eovf); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit ov;
        logic [31:0] er; logic edz, eovf;
        idle(2);
        do_op(16'h2400, 16'h0800, 1'b1, lat, bc, ov);
        model(16'h2400, 16'h0800, er, edz, eovf);
        checks++; if (lat !== 27 || div_result !== er)
            begin errors++; $display("FAIL hold_start got=%h lat=%0d want=%h lat=27", div_result, lat, er); end
        do_op(16'h8C00, 16'h1800, 1'b0, lat, bc, ov);
        model(16'h8C00, 16'h1800, er, edz, eovf);
        checks++; if (lat !== 27 || bc !== 27 || div_result !== er)
            begin errors++; $display("FAIL back_to_back got=%h lat=%0d busy=%0d want=%h 27 27", div_result, lat, bc, er); end
    endtask

    task automatic test_reset_midop();
        int lat, bc; bit ov; bit saw_done;
        logic [31:0] er; logic edz, eovf;
        idle(1);
        A = 16'h3000; B = 16'h0700; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, dz, ovf, div_result} !== 36'h0)
            begin errors++; $display("FAIL midop_reset_outputs got=%h want=0", {busy, done, dz, ovf, div_result}); end
        saw_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0)
            begin errors++; $display("FAIL midop_no_done got=1 want=0"); end
        do_op(16'h3000, 16'h0700, 1'b0, lat, bc, ov);
        model(16'h3000, 16'h0700, er, edz, eovf);
        checks++; if ({div_result, dz, ovf} !== {er, edz, eovf} || lat !== 27)
            begin errors++; $display("FAIL after_reset got=%h lat=%0d want=%h lat=27", div_result, lat, er); end
    endtask

    initial begin
        test_reset();
        test_unit();
        test_signed();
        test_dz();
        test_ovf_trunc();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
